// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: default bus widths, loop-filter FSM states and
// the signed saturation helper used by the loop filter, TDC and DCO wrappers.
// Combinational content only; no latency and no flow control.
package adpll_pkg;

  localparam int ADPLL_DELAY_WIDTH = 12;
  localparam int ADPLL_CW_WIDTH    = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INTEG = 2'd1,
    ST_OUT   = 2'd2
  } loop_state_t;

  // Symmetric saturation to +/-(2^(width-1)-1). The most negative code is
  // excluded so the range stays symmetric around zero.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (width - 1)) - 32'sd1;
    if (value > lim) return lim;
    else if (value < -lim) return -lim;
    return value;
  endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock detector: counts consecutive updates with |err| <= LOCK_THRESH.
// Counter moves on the upd strobe; locked follows one cycle later.
// No backpressure: one strobe per loop-filter update.
//   clk, reset : clock, synchronous active-high reset
//   err_mag    : magnitude of the captured phase error
//   upd        : high for the cycle in which the integrator updates
//   locked     : counter == LOCK_COUNT, registered
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int DELAY_WIDTH = ADPLL_DELAY_WIDTH,
  parameter int LOCK_THRESH = 4,
  parameter int LOCK_COUNT  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DELAY_WIDTH-1:0] err_mag,
  input  logic                   upd,
  output logic                   locked
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  logic [CNT_W-1:0] cnt;
  logic             upd_q;

  // The counter settles on the integrator edge; locked is refreshed one
  // edge later so it changes together with the new control word.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      upd_q  <= 1'b0;
      locked <= 1'b0;
    end else begin
      upd_q <= upd;
      if (upd) begin
        if (err_mag <= DELAY_WIDTH'(LOCK_THRESH)) begin
          if (cnt != CNT_W'(LOCK_COUNT)) cnt <= cnt + CNT_W'(1);
        end else begin
          cnt <= '0;
        end
      end
      if (upd_q) locked <= (cnt == CNT_W'(LOCK_COUNT));
    end
  end

endmodule

// File: rtl/adpll_loop_filter.sv
// ADPLL proportional-integral loop filter: TDC phase error -> DCO control word.
// Latency: edge captured at N, integrator at N+1, dco_ctrl/ctrl_valid at N+2.
// No backpressure: edges arriving mid-update are dropped and flag overrun.
//   clk, reset          : clock, synchronous active-high reset
//   tdc_delay/sign/valid: TDC magnitude, direction, measurement-done level
//   freeze              : ignore new measurements, hold loop state
//   dco_ctrl/ctrl_valid : clamped control word and its one-cycle update pulse
//   locked, overrun     : lock indicator, sticky dropped-measurement flag
module adpll_loop_filter
  import adpll_pkg::*;
#(
  parameter int DELAY_WIDTH = ADPLL_DELAY_WIDTH,
  parameter int CW_WIDTH    = ADPLL_CW_WIDTH,
  parameter int INT_WIDTH   = 20,
  parameter int CW_INIT     = 512,
  parameter int KP_SHIFT    = 2,
  parameter int KI_SHIFT    = 6,
  parameter int LOCK_THRESH = 4,
  parameter int LOCK_COUNT  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DELAY_WIDTH-1:0] tdc_delay,
  input  logic                   tdc_sign,
  input  logic                   tdc_valid,
  input  logic                   freeze,
  output logic [CW_WIDTH-1:0]    dco_ctrl,
  output logic                   ctrl_valid,
  output logic                   locked,
  output logic                   overrun
);

  localparam int CW_MAX = (1 << CW_WIDTH) - 1;

  loop_state_t                  state;
  logic                         valid_q;
  logic                         armed;
  logic                         rise;
  logic signed [DELAY_WIDTH:0]  err_in;
  logic signed [DELAY_WIDTH:0]  err_q;
  logic [DELAY_WIDTH-1:0]       mag_q;
  logic signed [INT_WIDTH-1:0]  integ;
  logic signed [31:0]           err_ext;
  logic signed [31:0]           integ_ext;
  logic signed [31:0]           sum;
  logic [CW_WIDTH-1:0]          cw_next;

  assign err_in = tdc_sign ? -$signed({1'b0, tdc_delay}) : $signed({1'b0, tdc_delay});

  // armed stays low until tdc_valid has been seen low, so a level that was
  // already high across reset release is not mistaken for a new measurement.
  assign rise = tdc_valid & ~valid_q & armed;

  assign err_ext   = 32'(err_q);
  assign integ_ext = 32'(integ);
  assign sum       = CW_INIT + (err_ext >>> KP_SHIFT) + (integ_ext >>> KI_SHIFT);

  always_comb begin
    cw_next = CW_WIDTH'(sum);
    if (sum < 0) cw_next = '0;
    else if (sum > CW_MAX) cw_next = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      valid_q    <= 1'b0;
      armed      <= ~tdc_valid;
      err_q      <= '0;
      mag_q      <= '0;
      integ      <= '0;
      dco_ctrl   <= CW_WIDTH'(CW_INIT);
      ctrl_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid_q    <= tdc_valid;
      armed      <= armed | ~tdc_valid;
      ctrl_valid <= 1'b0;
      if (state != ST_IDLE && rise && !freeze) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (rise && !freeze) begin
            err_q <= err_in;
            mag_q <= tdc_delay;
            state <= ST_INTEG;
          end
        end
        ST_INTEG: begin
          integ <= INT_WIDTH'(sat_signed(integ_ext + err_ext, INT_WIDTH));
          state <= ST_OUT;
        end
        ST_OUT: begin
          dco_ctrl   <= cw_next;
          ctrl_valid <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  adpll_lock_detect #(
    .DELAY_WIDTH (DELAY_WIDTH),
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_COUNT  (LOCK_COUNT)
  ) u_lock (
    .clk     (clk),
    .reset   (reset),
    .err_mag (mag_q),
    .upd     (state == ST_INTEG),
    .locked  (locked)
  );

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Directed bench for adpll_loop_filter: reset, latency, sign, saturation,
// lock, overrun/freeze and reset-abort scenarios with hand-computed values.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_adpll_loop_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] tdc_delay = '0;
  logic        tdc_sign = 1'b0;
  logic        tdc_valid = 1'b0;
  logic        freeze = 1'b0;
  logic [9:0]  dco_ctrl;
  logic        ctrl_valid;
  logic        locked;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adpll_loop_filter dut (
    .clk        (clk),
    .reset      (reset),
    .tdc_delay  (tdc_delay),
    .tdc_sign   (tdc_sign),
    .tdc_valid  (tdc_valid),
    .freeze     (freeze),
    .dco_ctrl   (dco_ctrl),
    .ctrl_valid (ctrl_valid),
    .locked     (locked),
    .overrun    (overrun)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; tdc_valid = 1'b0; freeze = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One measurement; returns whether ctrl_valid appeared (bounded wait) and
  // the locked value seen one cycle before that pulse.
  task automatic meas(input logic [11:0] d, input logic s,
                      output bit got, output logic lock_before);
    @(negedge clk);
    tdc_delay = d; tdc_sign = s; tdc_valid = 1'b1;
    @(negedge clk);
    tdc_valid = 1'b0;
    got = 1'b0;
    lock_before = locked;
    for (int i = 0; i < 6 && !got; i++) begin
      lock_before = locked;
      @(negedge clk);
      if (ctrl_valid) got = 1'b1;
    end
  endtask

  // Accepted edge, then a second edge two samples later (lands in OUT).
  task automatic run_pair(input logic frz0, input logic frz1, output int cv_cnt);
    cv_cnt = 0;
    @(negedge clk);
    tdc_delay = 12'd64; tdc_sign = 1'b0; tdc_valid = 1'b1; freeze = frz0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ctrl_valid) cv_cnt++;
      if (i == 1) begin tdc_valid = 1'b0; freeze = frz1; end
      if (i == 2) begin tdc_valid = 1'b1; tdc_delay = 12'd200; end
      if (i == 3) tdc_valid = 1'b0;
    end
    freeze = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dco_ctrl !== 10'd512) begin failures++; $display("FAIL reset_dco actual=%0d expected=512", dco_ctrl); end
    checks++; if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL reset_ctrl_valid actual=%0b expected=0", ctrl_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked actual=%0b expected=0", locked); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun actual=%0b expected=0", overrun); end
  endtask

  task automatic test_basic();
    logic cv [4];
    logic [9:0] dv [4];
    int exp_cv [4] = '{0, 0, 1, 0};
    do_reset();
    @(negedge clk);
    tdc_delay = 12'd64; tdc_sign = 1'b0; tdc_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tdc_valid = 1'b0;
      cv[k] = ctrl_valid; dv[k] = dco_ctrl;
      if (k == 1) begin
        checks++; if ($signed(dut.integ) !== 64) begin failures++; $display("FAIL basic_integ actual=%0d expected=64", $signed(dut.integ)); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (cv[k] !== exp_cv[k][0]) begin failures++; $display("FAIL basic_ctrl_valid_cycle%0d actual=%0b expected=%0d", k, cv[k], exp_cv[k]); end
    end
    checks++; if (dv[1] !== 10'd512) begin failures++; $display("FAIL basic_dco_early actual=%0d expected=512", dv[1]); end
    checks++; if (dv[2] !== 10'd529) begin failures++; $display("FAIL basic_dco actual=%0d expected=529", dv[2]); end
  endtask

  task automatic test_negative();
    bit got; logic lb;
    do_reset();
    meas(12'd64, 1'b1, got, lb);
    checks++; if (!got || dco_ctrl !== 10'd495) begin failures++; $display("FAIL neg_first got=%0b actual=%0d expected=495", got, dco_ctrl); end
    meas(12'd64, 1'b1, got, lb);
    checks++; if ($signed(dut.integ) !== -128) begin failures++; $display("FAIL neg_integ actual=%0d expected=-128", $signed(dut.integ)); end
    checks++; if (!got || dco_ctrl !== 10'd494) begin failures++; $display("FAIL neg_second got=%0b actual=%0d expected=494", got, dco_ctrl); end
  endtask

  task automatic test_saturation();
    bit got; logic lb;
    int bad = 0;
    do_reset();
    for (int n = 0; n < 130; n++) begin
      meas(12'd4095, 1'b0, got, lb);
      if (!got || dco_ctrl !== 10'd1023) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL sat_dco_high bad_updates=%0d expected=0 last=%0d", bad, dco_ctrl); end
    checks++; if ($signed(dut.integ) !== 524287) begin failures++; $display("FAIL sat_integ actual=%0d expected=524287", $signed(dut.integ)); end
    do_reset();
    meas(12'd4095, 1'b1, got, lb);
    checks++; if (!got || dco_ctrl !== 10'd0) begin failures++; $display("FAIL sat_dco_low got=%0b actual=%0d expected=0", got, dco_ctrl); end
  endtask

  task automatic test_lock();
    bit got; logic lb;
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      meas(12'd2, 1'b0, got, lb);
      if (n == 7) begin
        checks++; if (!got || locked !== 1'b0) begin failures++; $display("FAIL lock_7th got=%0b locked=%0b expected=0", got, locked); end
      end
    end
    checks++; if (!got || locked !== 1'b1 || lb !== 1'b0) begin failures++; $display("FAIL lock_rise got=%0b locked=%0b before=%0b expected=1/0", got, locked, lb); end
    meas(12'd10, 1'b0, got, lb);
    checks++; if (!got || locked !== 1'b0 || lb !== 1'b1) begin failures++; $display("FAIL lock_fall got=%0b locked=%0b before=%0b expected=0/1", got, locked, lb); end
  endtask

  task automatic test_back_to_back();
    int cv_cnt;
    do_reset();
    run_pair(1'b0, 1'b0, cv_cnt);
    checks++; if (cv_cnt !== 1) begin failures++; $display("FAIL b2b_pulses actual=%0d expected=1", cv_cnt); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun actual=%0b expected=1", overrun); end
    checks++; if (dco_ctrl !== 10'd529) begin failures++; $display("FAIL b2b_dco actual=%0d expected=529", dco_ctrl); end
    do_reset();
    run_pair(1'b1, 1'b1, cv_cnt);
    checks++; if (cv_cnt !== 0) begin failures++; $display("FAIL freeze_pulses actual=%0d expected=0", cv_cnt); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL freeze_overrun actual=%0b expected=0", overrun); end
    checks++; if (dco_ctrl !== 10'd512) begin failures++; $display("FAIL freeze_dco actual=%0d expected=512", dco_ctrl); end
    do_reset();
    run_pair(1'b0, 1'b1, cv_cnt);
    checks++; if (cv_cnt !== 1 || dco_ctrl !== 10'd529) begin failures++; $display("FAIL freeze_inflight pulses=%0d dco=%0d expected=1/529", cv_cnt, dco_ctrl); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL freeze_inflight_overrun actual=%0b expected=0", overrun); end
  endtask

  task automatic test_reset_mid();
    bit got; logic lb;
    int cv_cnt = 0;
    do_reset();
    for (int n = 0; n < 8; n++) meas(12'd2, 1'b0, got, lb);
    @(negedge clk);
    tdc_delay = 12'd64; tdc_sign = 1'b0; tdc_valid = 1'b1;
    @(negedge clk);
    tdc_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ctrl_valid) cv_cnt++;
    end
    checks++; if (cv_cnt !== 0) begin failures++; $display("FAIL abort_pulses actual=%0d expected=0", cv_cnt); end
    checks++; if (dco_ctrl !== 10'd512) begin failures++; $display("FAIL abort_dco actual=%0d expected=512", dco_ctrl); end
    checks++; if ($signed(dut.integ) !== 0) begin failures++; $display("FAIL abort_integ actual=%0d expected=0", $signed(dut.integ)); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL abort_locked actual=%0b expected=0", locked); end

    cv_cnt = 0;
    @(negedge clk);
    tdc_delay = 12'd64; tdc_sign = 1'b0; tdc_valid = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ctrl_valid) cv_cnt++;
    end
    checks++; if (cv_cnt !== 0 || dco_ctrl !== 10'd512) begin failures++; $display("FAIL held_high pulses=%0d dco=%0d expected=0/512", cv_cnt, dco_ctrl); end
    tdc_valid = 1'b0;
    meas(12'd64, 1'b0, got, lb);
    checks++; if (!got || dco_ctrl !== 10'd529) begin failures++; $display("FAIL after_fall got=%0b dco=%0d expected=1/529", got, dco_ctrl); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
